// File: rtl/com_pkg.sv
// com_pkg: shared widths, state encoding and RGB565 hit test for the mask streamer
package com_pkg;
  localparam int X_W = 11;
  localparam int Y_W = 10;
  localparam int CNT_W = 20;
  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;

  typedef enum logic [1:0] {IDLE, SCAN, TAB} streamer_state_t;

  // Blue is doubled so it is compared on the same 6-bit scale as green.
  function automatic logic is_hit(input logic [15:0] p, input logic [4:0] red_min, input logic [5:0] gb_max);
    return (p[R_HI:R_LO] >= red_min) && (p[G_HI:G_LO] < gb_max) && ({p[B_HI:B_LO], 1'b0} < gb_max);
  endfunction
endpackage

// File: rtl/rgb_threshold.sv
// rgb_threshold: registered mask hit for one accepted pixel beat
module rgb_threshold
  import com_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pixel,
  input  logic        en,
  input  logic [4:0]  red_min,
  input  logic [5:0]  gb_max,
  output logic        hit
);
  // One-cycle hit pulse aligned with the coordinate register; low when no beat.
  always_ff @(posedge clk)
    if (rst) hit <= 1'b0;
    else hit <= en && is_hit(pixel, red_min, gb_max);
endmodule

// File: rtl/mask_pixel_streamer.sv
// mask_pixel_streamer: thresholds a raster RGB565 stream into (x,y,valid) beats and requests tabulation per frame
module mask_pixel_streamer
  import com_pkg::*;
#(
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 768,
  parameter int TAB_TIMEOUT = 4096
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [15:0]      pixel_in,
  input  logic             pixel_valid_in,
  input  logic             frame_start_in,
  input  logic [4:0]       red_min_in,
  input  logic [5:0]       gb_max_in,
  input  logic             com_valid_in,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic             valid_out,
  output logic             tabulate_out,
  output logic [CNT_W-1:0] hit_count_out,
  output logic             busy_out,
  output logic             frame_err_out
);
  localparam int TW = $clog2(TAB_TIMEOUT + 1);
  localparam logic [X_W-1:0] X_MAX = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_ACTIVE - 1);

  streamer_state_t  state;
  logic [X_W-1:0]   x_cnt, bx;
  logic [Y_W-1:0]   y_cnt, by;
  logic [CNT_W-1:0] hits, hits_base, hits_next;
  logic [TW-1:0]    tcnt;
  logic             beat, last, timeout;

  // A beat is accepted in SCAN, or in IDLE only when it marks a frame start; a start beat is always (0,0).
  assign beat    = pixel_valid_in && (state == SCAN || (state == IDLE && frame_start_in));
  assign bx      = frame_start_in ? '0 : x_cnt;
  assign by      = frame_start_in ? '0 : y_cnt;
  assign last    = bx == X_MAX && by == Y_MAX;
  assign timeout = tcnt == TW'(TAB_TIMEOUT - 1);

  // Running hit count including the current beat, restarted by a frame start and saturating.
  always_comb begin
    hits_base = frame_start_in ? '0 : hits;
    hits_next = (is_hit(pixel_in, red_min_in, gb_max_in) && hits_base != '1) ? hits_base + CNT_W'(1) : hits_base;
  end

  rgb_threshold u_thr (
    .clk     (clk_in),
    .rst     (rst_in),
    .pixel   (pixel_in),
    .en      (beat),
    .red_min (red_min_in),
    .gb_max  (gb_max_in),
    .hit     (valid_out)
  );

  // Frame sequencer with registered coordinate, request, status and error outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      x_cnt         <= '0;
      y_cnt         <= '0;
      hits          <= '0;
      tcnt          <= '0;
      x_out         <= '0;
      y_out         <= '0;
      tabulate_out  <= 1'b0;
      hit_count_out <= '0;
      busy_out      <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      if (beat) begin
        x_out <= bx;
        y_out <= by;
        x_cnt <= bx == X_MAX ? '0 : bx + X_W'(1);
        y_cnt <= bx == X_MAX ? by + Y_W'(1) : by;
        hits  <= hits_next;
      end
      case (state)
        IDLE, SCAN: begin
          if (state == SCAN && pixel_valid_in && frame_start_in) frame_err_out <= 1'b1;
          if (beat) begin
            busy_out     <= 1'b1;
            state        <= last ? TAB : SCAN;
            tabulate_out <= last;
            tcnt         <= '0;
            if (last) hit_count_out <= hits_next;
          end
        end
        TAB: begin
          if (pixel_valid_in) frame_err_out <= 1'b1;
          if (com_valid_in || timeout) begin
            state        <= IDLE;
            tabulate_out <= 1'b0;
            busy_out     <= 1'b0;
            if (!com_valid_in) frame_err_out <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mask_pixel_streamer.sv
// tb_mask_pixel_streamer: randomized and directed frames checked against a pixel-index reference model
module tb_mask_pixel_streamer;
  localparam int H = 8;
  localparam int V = 4;
  localparam int T = 16;
  localparam int N = H * V;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pixel_in = '0;
  logic        pixel_valid_in = 1'b0;
  logic        frame_start_in = 1'b0;
  logic [4:0]  red_min = 5'd16;
  logic [5:0]  gb_max = 6'd8;
  logic        com_valid_in = 1'b0;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        valid_out, tabulate_out, busy_out, frame_err_out;
  logic [19:0] hit_count_out;

  int checks = 0;
  int errors = 0;
  logic [15:0] frame [N];
  int hits, n;

  always #5 clk = ~clk;

  mask_pixel_streamer #(.H_ACTIVE(H), .V_ACTIVE(V), .TAB_TIMEOUT(T)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .pixel_in       (pixel_in),
    .pixel_valid_in (pixel_valid_in),
    .frame_start_in (frame_start_in),
    .red_min_in     (red_min),
    .gb_max_in      (gb_max),
    .com_valid_in   (com_valid_in),
    .x_out          (x_out),
    .y_out          (y_out),
    .valid_out      (valid_out),
    .tabulate_out   (tabulate_out),
    .hit_count_out  (hit_count_out),
    .busy_out       (busy_out),
    .frame_err_out  (frame_err_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_hit(input logic [15:0] p);
    int r, g, b;
    r = int'(p) / 2048;
    g = (int'(p) / 32) % 64;
    b = int'(p) % 32;
    return r >= int'(red_min) && g < int'(gb_max) && 2 * b < int'(gb_max);
  endfunction

  // Inputs change at negedge; after return the DUT has taken one posedge and outputs are settled.
  task automatic drive(input logic [15:0] p, input logic fs, input logic v);
    pixel_in = p;
    frame_start_in = fs;
    pixel_valid_in = v;
    @(negedge clk);
    pixel_valid_in = 1'b0;
    frame_start_in = 1'b0;
  endtask

  task automatic send_frame(input int gap_max, output int nh);
    bit e;
    nh = 0;
    for (int i = 0; i < N; i++) begin
      drive(frame[i], i == 0, 1'b1);
      e = ref_hit(frame[i]);
      chk("valid", {31'd0, valid_out}, {31'd0, e});
      if (e) begin
        chk("x", {21'd0, x_out}, i % H);
        chk("y", {22'd0, y_out}, i / H);
        nh++;
      end
      chk("tab_at_beat", {31'd0, tabulate_out}, {31'd0, i == N - 1});
      chk("busy_in_frame", {31'd0, busy_out}, 1);
      if (i < N - 1)
        repeat ($urandom_range(gap_max, 0)) begin
          drive(16'($urandom), 1'b0, 1'b0);
          chk("gap_valid", {31'd0, valid_out}, 0);
        end
    end
  endtask

  task automatic tab_len(output int cnt);
    cnt = 0;
    while (tabulate_out && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_x"}, {21'd0, x_out}, 0);
    chk({tag, "_y"}, {22'd0, y_out}, 0);
    chk({tag, "_valid"}, {31'd0, valid_out}, 0);
    chk({tag, "_tab"}, {31'd0, tabulate_out}, 0);
    chk({tag, "_count"}, {12'd0, hit_count_out}, 0);
    chk({tag, "_busy"}, {31'd0, busy_out}, 0);
    chk({tag, "_err"}, {31'd0, frame_err_out}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // all-red frame, completion acknowledged on the fourth tabulate cycle
    for (int i = 0; i < N; i++) frame[i] = 16'hF800;
    send_frame(0, hits);
    chk("allred_hits", hits, N);
    chk("allred_count", {12'd0, hit_count_out}, N);
    for (int k = 0; k < 4; k++) begin
      chk("tab_hold", {31'd0, tabulate_out}, 1);
      if (k == 3) com_valid_in = 1'b1;
      @(negedge clk);
      com_valid_in = 1'b0;
    end
    chk("tab_drop", {31'd0, tabulate_out}, 0);
    chk("busy_drop", {31'd0, busy_out}, 0);
    chk("ack_err", {31'd0, frame_err_out}, 0);

    // random frames with gaps, next frame starts right after the acknowledge
    for (int f = 0; f < 3; f++) begin
      red_min = 5'($urandom);
      gb_max = 6'($urandom_range(63, 1));
      for (int i = 0; i < N; i++) frame[i] = 16'($urandom);
      frame[0] = 16'hF800;
      send_frame(2, hits);
      chk("rand_count", {12'd0, hit_count_out}, hits);
      repeat ($urandom_range(5, 0)) @(negedge clk);
      chk("rand_tab", {31'd0, tabulate_out}, 1);
      com_valid_in = 1'b1;
      @(negedge clk);
      com_valid_in = 1'b0;
      chk("rand_tab_drop", {31'd0, tabulate_out}, 0);
      chk("rand_err", {31'd0, frame_err_out}, 0);
    end

    // single hit at (5,2), then tabulate times out
    red_min = 5'd16;
    gb_max = 6'd8;
    for (int i = 0; i < N; i++) frame[i] = 16'h07E0;
    frame[2 * H + 5] = 16'hF800;
    send_frame(1, hits);
    chk("single_hits", hits, 1);
    chk("single_count", {12'd0, hit_count_out}, 1);
    tab_len(n);
    chk("timeout_len", n, T);
    chk("timeout_err", {31'd0, frame_err_out}, 1);
    chk("timeout_busy", {31'd0, busy_out}, 0);

    // short frame: restart at beat 10
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst2");
    for (int i = 0; i < N; i++) frame[i] = 16'hF800;
    for (int i = 0; i < 10; i++) drive(16'hF800, i == 0, 1'b1);
    chk("pre_restart_x", {21'd0, x_out}, 9 % H);
    chk("pre_restart_err", {31'd0, frame_err_out}, 0);
    send_frame(0, hits);
    chk("restart_err", {31'd0, frame_err_out}, 1);
    chk("restart_count", {12'd0, hit_count_out}, N);

    // pixels during TAB are dropped, then reset mid-TAB
    drive(16'hF800, 1'b0, 1'b1);
    chk("tab_drop_valid", {31'd0, valid_out}, 0);
    chk("tab_drop_tab", {31'd0, tabulate_out}, 1);
    drive(16'hF800, 1'b1, 1'b1);
    chk("tab_fs_valid", {31'd0, valid_out}, 0);
    chk("tab_fs_busy", {31'd0, busy_out}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst_tab");
    drive(16'hF800, 1'b0, 1'b1);
    chk("idle_no_start_valid", {31'd0, valid_out}, 0);
    chk("idle_no_start_busy", {31'd0, busy_out}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
